// File: rtl/jt12_snd_mixer.sv
// Latches one FM stereo pair plus a PSG level per strobe, mixes them with independent
// gains through one shared multiplier, saturates, and offers the sample over valid/ready.
module jt12_snd_mixer #(
  parameter int FM_W   = 16,
  parameter int PSG_W  = 10,
  parameter int OUT_W  = 16,
  parameter int GAIN_W = 8,
  parameter int STEREO = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cen,
  input  logic                     snd_sample,
  input  logic signed [FM_W-1:0]   fm_l,
  input  logic signed [FM_W-1:0]   fm_r,
  input  logic        [PSG_W-1:0]  psg,
  input  logic        [GAIN_W-1:0] gain_fm,
  input  logic        [GAIN_W-1:0] gain_psg,
  input  logic                     mute,
  output logic signed [OUT_W-1:0]  snd_left,
  output logic signed [OUT_W-1:0]  snd_right,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     ovf,
  output logic                     drop,
  input  logic                     flag_clr
);

  localparam int ACC_W = FM_W + GAIN_W + 2;

  typedef enum logic [2:0] {IDLE, MPSG, ML, MR, HOLD} state_t;

  state_t                    state_q, state_d;
  logic signed [FM_W-1:0]    fm_l_q, fm_l_d, fm_r_q, fm_r_d;
  logic        [PSG_W-1:0]   psg_q, psg_d;
  logic        [GAIN_W-1:0]  gain_fm_q, gain_fm_d, gain_psg_q, gain_psg_d;
  logic signed [ACC_W-1:0]   p_q, p_d;
  logic signed [OUT_W-1:0]   left_q, left_d;
  logic                      left_clip_q, left_clip_d;
  logic signed [OUT_W-1:0]   snd_left_q, snd_left_d, snd_right_q, snd_right_d;
  logic                      ovf_q, ovf_d, drop_q, drop_d;
  logic                      ovf_set, drop_set;

  logic signed [PSG_W:0]     psg_s;
  logic signed [FM_W:0]      psg_al;
  logic signed [FM_W:0]      mul_a;
  logic        [GAIN_W-1:0]  mul_g;
  logic signed [ACC_W-1:0]   mul_a_x, mul_b_x, prod, acc;
  logic        [OUT_W:0]     sat_res;

  // Returns {clip, value}: acc scaled back from Q.4 and clamped to the output range.
  function automatic logic [OUT_W:0] sat_fn(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    sh = a >>> 4;
    if ((&sh[ACC_W-1:OUT_W-1]) || !(|sh[ACC_W-1:OUT_W-1]))
      return {1'b0, sh[OUT_W-1:0]};
    else if (sh[ACC_W-1])
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  // Offset-binary PSG to signed is just an MSB inversion plus sign extension.
  assign psg_s  = {~psg_q[PSG_W-1], ~psg_q[PSG_W-1], psg_q[PSG_W-2:0]};
  assign psg_al = (FM_W+1)'(psg_s) <<< (FM_W - PSG_W);

  always_comb begin
    mul_a = (FM_W+1)'(fm_l_q);
    mul_g = gain_fm_q;
    case (state_q)
      MPSG:    begin mul_a = psg_al; mul_g = gain_psg_q; end
      MR:      mul_a = (FM_W+1)'(fm_r_q);
      default: ;
    endcase
  end

  assign mul_a_x = ACC_W'(mul_a);
  assign mul_b_x = ACC_W'(mul_g);
  assign prod    = mul_a_x * mul_b_x;
  assign acc     = prod + p_q;
  assign sat_res = sat_fn(acc);

  always_comb begin
    state_d     = state_q;
    fm_l_d      = fm_l_q;
    fm_r_d      = fm_r_q;
    psg_d       = psg_q;
    gain_fm_d   = gain_fm_q;
    gain_psg_d  = gain_psg_q;
    p_d         = p_q;
    left_d      = left_q;
    left_clip_d = left_clip_q;
    snd_left_d  = snd_left_q;
    snd_right_d = snd_right_q;
    ovf_set     = 1'b0;
    drop_set    = cen && snd_sample && (state_q != IDLE);
    case (state_q)
      IDLE: if (cen && snd_sample) begin
        fm_l_d     = fm_l;
        fm_r_d     = fm_r;
        psg_d      = psg;
        gain_fm_d  = mute ? '0 : gain_fm;
        gain_psg_d = mute ? '0 : gain_psg;
        state_d    = MPSG;
      end
      MPSG: if (cen) begin
        p_d     = prod;
        state_d = ML;
      end
      ML: if (cen) begin
        if (STEREO != 0) begin
          left_d      = sat_res[OUT_W-1:0];
          left_clip_d = sat_res[OUT_W];
          state_d     = MR;
        end else begin
          snd_left_d  = sat_res[OUT_W-1:0];
          snd_right_d = sat_res[OUT_W-1:0];
          ovf_set     = sat_res[OUT_W];
          state_d     = HOLD;
        end
      end
      MR: if (cen) begin
        snd_left_d  = left_q;
        snd_right_d = sat_res[OUT_W-1:0];
        ovf_set     = left_clip_q | sat_res[OUT_W];
        state_d     = HOLD;
      end
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A set on the same edge as a clear wins.
    ovf_d  = (ovf_q  && !flag_clr) || ovf_set;
    drop_d = (drop_q && !flag_clr) || drop_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fm_l_q      <= '0;
      fm_r_q      <= '0;
      psg_q       <= '0;
      gain_fm_q   <= '0;
      gain_psg_q  <= '0;
      p_q         <= '0;
      left_q      <= '0;
      left_clip_q <= 1'b0;
      snd_left_q  <= '0;
      snd_right_q <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fm_l_q      <= fm_l_d;
      fm_r_q      <= fm_r_d;
      psg_q       <= psg_d;
      gain_fm_q   <= gain_fm_d;
      gain_psg_q  <= gain_psg_d;
      p_q         <= p_d;
      left_q      <= left_d;
      left_clip_q <= left_clip_d;
      snd_left_q  <= snd_left_d;
      snd_right_q <= snd_right_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  assign snd_left  = snd_left_q;
  assign snd_right = snd_right_q;
  assign out_valid = (state_q == HOLD);
  assign ovf       = ovf_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_jt12_snd_mixer.sv
// Drives a stereo and a mono mixer with shared stimulus and checks both every cycle
// against a transaction-level model, plus literal expectations for known mixes.
module tb_jt12_snd_mixer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cen = 1'b0, snd_sample = 1'b0, mute = 1'b0, out_ready = 1'b0, flag_clr = 1'b0;
  logic signed [15:0] fm_l = '0, fm_r = '0;
  logic [9:0] psg = '0;
  logic [7:0] gain_fm = '0, gain_psg = '0;

  logic signed [15:0] snd_left_s, snd_right_s, snd_left_m, snd_right_m;
  logic out_valid_s, out_valid_m, ovf_s, ovf_m, drop_s, drop_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jt12_snd_mixer #(.STEREO(1)) u_st (
    .clk(clk), .rst_n(rst_n), .cen(cen), .snd_sample(snd_sample),
    .fm_l(fm_l), .fm_r(fm_r), .psg(psg), .gain_fm(gain_fm), .gain_psg(gain_psg),
    .mute(mute), .snd_left(snd_left_s), .snd_right(snd_right_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .ovf(ovf_s), .drop(drop_s),
    .flag_clr(flag_clr)
  );

  jt12_snd_mixer #(.STEREO(0)) u_mo (
    .clk(clk), .rst_n(rst_n), .cen(cen), .snd_sample(snd_sample),
    .fm_l(fm_l), .fm_r(fm_r), .psg(psg), .gain_fm(gain_fm), .gain_psg(gain_psg),
    .mute(mute), .snd_left(snd_left_m), .snd_right(snd_right_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .ovf(ovf_m), .drop(drop_m),
    .flag_clr(flag_clr)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: value = clamp(floor((fm*gf + (psg-512)*64*gp)/16)).
  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int mix_raw(input int f, input int p, input int gf, input int gp);
    int acc;
    acc = f * gf + (p - 512) * 64 * gp;
    return acc >>> 4;
  endfunction

  // Model per instance (0 = stereo, 1 = mono): a pending sample counts down cen edges.
  bit m_busy[2], m_valid[2], m_pclip[2], m_ovf[2], m_drop[2];
  int m_cnt[2], m_pl[2], m_pr[2], m_l[2], m_r[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_valid[k] = 0; m_pclip[k] = 0; m_ovf[k] = 0; m_drop[k] = 0;
        m_cnt[k] = 0; m_pl[k] = 0; m_pr[k] = 0; m_l[k] = 0; m_r[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit os, ds;
        int gf, gp, rl, rr;
        os = 0; ds = 0;
        if (m_valid[k]) begin
          if (cen && snd_sample) ds = 1;
          if (out_ready) m_valid[k] = 0;
        end else if (m_busy[k]) begin
          if (cen) begin
            if (snd_sample) ds = 1;
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin
              m_busy[k] = 0; m_valid[k] = 1;
              m_l[k] = m_pl[k]; m_r[k] = m_pr[k]; os = m_pclip[k];
            end
          end
        end else if (cen && snd_sample) begin
          gf = mute ? 0 : int'(gain_fm);
          gp = mute ? 0 : int'(gain_psg);
          rl = mix_raw(int'(fm_l), int'(psg), gf, gp);
          rr = (k == 0) ? mix_raw(int'(fm_r), int'(psg), gf, gp) : rl;
          m_pl[k] = clamp16(rl);
          m_pr[k] = clamp16(rr);
          m_pclip[k] = (m_pl[k] != rl) || (m_pr[k] != rr);
          m_busy[k] = 1;
          m_cnt[k] = (k == 0) ? 3 : 2;
        end
        m_ovf[k]  = (m_ovf[k] && !flag_clr) || os;
        m_drop[k] = (m_drop[k] && !flag_clr) || ds;
      end
    end
  end

  always @(negedge clk) begin
    chk("s_valid", int'(out_valid_s), int'(m_valid[0]));
    chk("s_left",  int'(snd_left_s),  m_l[0]);
    chk("s_right", int'(snd_right_s), m_r[0]);
    chk("s_ovf",   int'(ovf_s),       int'(m_ovf[0]));
    chk("s_drop",  int'(drop_s),      int'(m_drop[0]));
    chk("m_valid", int'(out_valid_m), int'(m_valid[1]));
    chk("m_left",  int'(snd_left_m),  m_l[1]);
    chk("m_right", int'(snd_right_m), m_r[1]);
    chk("m_ovf",   int'(ovf_m),       int'(m_ovf[1]));
    chk("m_drop",  int'(drop_m),      int'(m_drop[1]));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input int fl, input int fr, input int p, input int gf, input int gp,
                        input bit mu);
    fm_l = 16'(fl); fm_r = 16'(fr); psg = 10'(p);
    gain_fm = 8'(gf); gain_psg = 8'(gp); mute = mu;
  endtask

  // Strobe one sample with cen=1 and wait (bounded) until the stereo output is valid.
  task automatic run_sample(input int fl, input int fr, input int p, input int gf,
                            input int gp, input bit mu);
    int n;
    set_in(fl, fr, p, gf, gp, mu);
    snd_sample = 1'b1;
    tick();
    snd_sample = 1'b0;
    n = 0;
    while (!out_valid_s && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid_s) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cen = 1'b1;
    repeat (3) tick();
    chk("rst_valid", int'(out_valid_s), 0);
    chk("rst_left",  int'(snd_left_s), 0);
    chk("rst_ovf",   int'(ovf_s), 0);
    chk("rst_drop",  int'(drop_s), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Unity mix with explicit latency: stereo valid after E3, mono after E2.
    set_in(1000, -1000, 512, 'h10, 'h10, 0);
    snd_sample = 1'b1;
    tick();
    snd_sample = 1'b0;
    tick();
    tick();
    chk("uni_s_valid_e2", int'(out_valid_s), 0);
    chk("uni_m_valid_e2", int'(out_valid_m), 1);
    chk("uni_m_left", int'(snd_left_m), 1000);
    chk("uni_m_right", int'(snd_right_m), 1000);
    tick();
    chk("uni_s_valid_e3", int'(out_valid_s), 1);
    chk("uni_s_left", int'(snd_left_s), 1000);
    chk("uni_s_right", int'(snd_right_s), -1000);
    chk("uni_ovf", int'(ovf_s), 0);
    repeat (2) tick();

    run_sample(0, 0, 1023, 'h10, 'h10, 0);
    chk("psg_hi_l", int'(snd_left_s), 32704);
    chk("psg_hi_r", int'(snd_right_s), 32704);
    repeat (2) tick();
    run_sample(0, 0, 0, 'h10, 'h10, 0);
    chk("psg_lo_l", int'(snd_left_s), -32768);
    chk("psg_lo_r", int'(snd_right_s), -32768);
    chk("psg_lo_ovf", int'(ovf_s), 0);
    repeat (2) tick();

    run_sample('h7FFF, 0, 512, 'h20, 'h10, 0);
    chk("sat_left", int'(snd_left_s), 32767);
    chk("sat_right", int'(snd_right_s), 0);
    chk("sat_ovf", int'(ovf_s), 1);
    repeat (2) tick();
    run_sample(100, 100, 512, 'h10, 'h10, 0);
    chk("sat_clean_left", int'(snd_left_s), 100);
    chk("sat_ovf_sticky", int'(ovf_s), 1);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("sat_ovf_clr", int'(ovf_s), 0);
    tick();

    out_ready = 1'b0;
    run_sample(1234, -42, 512, 'h10, 'h10, 0);
    set_in(7, 7, 100, 'h30, 'h30, 0);
    snd_sample = 1'b1;
    tick();
    snd_sample = 1'b0;
    tick();
    chk("bp_drop", int'(drop_s), 1);
    chk("bp_drop_mono", int'(drop_m), 1);
    chk("bp_valid_held", int'(out_valid_s), 1);
    chk("bp_left_held", int'(snd_left_s), 1234);
    chk("bp_right_held", int'(snd_right_s), -42);
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", int'(out_valid_s), 0);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("bp_drop_clr", int'(drop_s), 0);

    run_sample(300, -5, 512, 'h10, 'h10, 0);
    chk("mono_s_right", int'(snd_right_s), -5);
    chk("mono_m_left", int'(snd_left_m), 300);
    chk("mono_m_right", int'(snd_right_m), 300);
    repeat (2) tick();
    run_sample(300, -5, 700, 'h10, 'h10, 1);
    chk("mute_s_left", int'(snd_left_s), 0);
    chk("mute_s_right", int'(snd_right_s), 0);
    chk("mute_m_left", int'(snd_left_m), 0);
    repeat (2) tick();

    // Quarter-rate cen: same result, stretched in time.
    set_in(1000, -1000, 512, 'h10, 'h10, 0);
    for (int i = 0; i < 24; i++) begin
      cen = (i % 4 == 0);
      snd_sample = (i == 0);
      tick();
    end
    snd_sample = 1'b0;
    cen = 1'b1;
    chk("cen_left", int'(snd_left_s), 1000);
    chk("cen_right", int'(snd_right_s), -1000);
    repeat (2) tick();

    // Reset while the stereo mixer sits in MR.
    set_in(2000, 3000, 512, 'h10, 'h10, 0);
    snd_sample = 1'b1;
    tick();
    snd_sample = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstmr_valid", int'(out_valid_s), 0);
    chk("rstmr_left", int'(snd_left_s), 0);
    chk("rstmr_m_left", int'(snd_left_m), 0);
    tick();
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      chk("rstmr_no_emit", int'(out_valid_s), 0);
    end

    for (int i = 0; i < 3000; i++) begin
      cen        = ($urandom % 4) != 0;
      snd_sample = ($urandom % 3) == 0;
      out_ready  = ($urandom % 4) != 0;
      flag_clr   = ($urandom % 32) == 0;
      mute       = ($urandom % 16) == 0;
      fm_l       = 16'($urandom);
      fm_r       = 16'($urandom);
      psg        = 10'($urandom);
      gain_fm    = ($urandom % 8 == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
      gain_psg   = ($urandom % 8 == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
